// File: rtl/logic_sweep_ctrl.sv
// -----------------------------------------------------------------------------
// logic_sweep_ctrl
//
// Self-test sequencer for a small combinational cell with N_IN 1-bit inputs
// and one output. On start it walks every input vector 0..2**N_IN-1 in
// ascending order. Each vector is held for SETTLE+1 cycles, and the cell
// output is sampled in one extra cycle. The measured truth table is compared
// against a copy of the expected table taken when the sweep was accepted.
//
// Ports
//   clk      in   1         rising-edge clock
//   rst_n    in   1         synchronous, active-low reset
//   start    in   1         sweep request, honoured only when idle
//   exp_tt   in   2**N_IN   expected table, bit i = expected y for vector i
//   dut_in   out  N_IN      vector driven to the cell (MSB = first input)
//   dut_y    in   1         cell output
//   busy     out  1         high while a sweep is running
//   done     out  1         one-cycle pulse in the first idle cycle after a sweep
//   tt_out   out  2**N_IN   measured table, bit i = sampled dut_y for vector i
//   err_cnt  out  N_IN+1    number of bits where tt_out differs from exp_tt
//   pass     out  1         last completed sweep had err_cnt == 0
// -----------------------------------------------------------------------------
module logic_sweep_ctrl #(
    parameter int N_IN   = 3,   // 1..6
    parameter int SETTLE = 1    // 0..15
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                start,
    input  logic [2**N_IN-1:0]  exp_tt,
    output logic [N_IN-1:0]     dut_in,
    input  logic                dut_y,
    output logic                busy,
    output logic                done,
    output logic [2**N_IN-1:0]  tt_out,
    output logic [N_IN:0]       err_cnt,
    output logic                pass
);

    localparam int              N_VEC      = 2**N_IN;
    localparam int              ERR_W      = N_IN + 1;
    localparam logic [N_IN-1:0] LAST_VEC   = '1;
    localparam logic [3:0]      SETTLE_CNT = 4'(SETTLE);

    typedef enum logic [1:0] {
        S_IDLE,
        S_HOLD,
        S_SAMPLE
    } state_t;

    state_t             state_q,    state_d;
    logic [N_IN-1:0]    dut_in_q,   dut_in_d;
    logic [3:0]         hold_q,     hold_d;
    logic [N_VEC-1:0]   exp_q,      exp_d;
    logic [N_VEC-1:0]   tt_q,       tt_d;
    logic [ERR_W-1:0]   err_q,      err_d;
    logic               pass_q,     pass_d;
    logic               done_q,     done_d;

    logic               mismatch;
    logic [ERR_W-1:0]   err_next;

    // NOTE: sequential state uses non-blocking assignments only, so every
    // register sees the values from before the edge regardless of order.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            dut_in_q <= '0;
            hold_q   <= '0;
            exp_q    <= '0;
            tt_q     <= '0;
            err_q    <= '0;
            pass_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            dut_in_q <= dut_in_d;
            hold_q   <= hold_d;
            exp_q    <= exp_d;
            tt_q     <= tt_d;
            err_q    <= err_d;
            pass_q   <= pass_d;
            done_q   <= done_d;
        end
    end

    // Compare of the current vector against the table latched at start.
    assign mismatch = dut_y ^ exp_q[dut_in_q];
    assign err_next = err_q + ERR_W'(mismatch);

    // NOTE: every signal written here gets a default first, so no path can
    // leave one unassigned and infer a latch.
    always_comb begin
        state_d  = state_q;
        dut_in_d = dut_in_q;
        hold_d   = hold_q;
        exp_d    = exp_q;
        tt_d     = tt_q;
        err_d    = err_q;
        pass_d   = pass_q;
        done_d   = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d  = S_HOLD;
                    exp_d    = exp_tt;
                    tt_d     = '0;
                    err_d    = '0;
                    pass_d   = 1'b0;
                    dut_in_d = '0;
                    hold_d   = '0;
                end
            end

            // hold_cnt runs 0..SETTLE, giving SETTLE+1 settling cycles.
            S_HOLD: begin
                if (hold_q == SETTLE_CNT) begin
                    state_d = S_SAMPLE;
                end else begin
                    hold_d = hold_q + 4'd1;
                end
            end

            S_SAMPLE: begin
                tt_d[dut_in_q] = dut_y;
                err_d          = err_next;
                if (dut_in_q == LAST_VEC) begin
                    // pass includes the compare of the final vector.
                    state_d  = S_IDLE;
                    done_d   = 1'b1;
                    dut_in_d = '0;
                    pass_d   = (err_next == '0);
                end else begin
                    state_d  = S_HOLD;
                    dut_in_d = dut_in_q + 1'b1;
                    hold_d   = '0;
                end
            end

            default: state_d = S_IDLE;
        endcase
    end

    assign busy    = (state_q != S_IDLE);
    assign done    = done_q;
    assign dut_in  = dut_in_q;
    assign tt_out  = tt_q;
    assign err_cnt = err_q;
    assign pass    = pass_q;

endmodule

// File: tb/tb_logic_sweep_ctrl.sv
// -----------------------------------------------------------------------------
// tb_logic_sweep_ctrl
//
// Directed bench for logic_sweep_ctrl. Two instances share the clock: the
// main one (N_IN=3, SETTLE=1) and a SETTLE=0 one driven with start held high
// for back-to-back sweeps. The cell under test is modelled as y = a & b.
// Expected sweep results are pushed to a scoreboard queue when a sweep is
// launched and popped when the DUT signals done.
// -----------------------------------------------------------------------------
module tb_logic_sweep_ctrl;

    typedef struct {
        logic [7:0] tt;
        logic [3:0] err;
        logic       pass;
    } result_t;

    logic       clk = 1'b0;
    int         tests = 0;
    int         fails = 0;
    result_t    sb[$];

    // Main instance, SETTLE = 1
    logic       rst_n, start, busy, done, pass, dut_y;
    logic [7:0] exp_tt, tt_out;
    logic [2:0] dut_in;
    logic [3:0] err_cnt;

    // Second instance, SETTLE = 0
    logic       rst0_n, start0, busy0, done0, pass0, dut_y0;
    logic [7:0] exp_tt0, tt_out0;
    logic [2:0] dut_in0;
    logic [3:0] err_cnt0;

    always #5 clk = ~clk;

    // Cell model: y = a & b with a = dut_in[2], b = dut_in[1].
    assign dut_y  = dut_in[2]  & dut_in[1];
    assign dut_y0 = dut_in0[2] & dut_in0[1];

    logic_sweep_ctrl #(.N_IN(3), .SETTLE(1)) u_dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .start   (start),
        .exp_tt  (exp_tt),
        .dut_in  (dut_in),
        .dut_y   (dut_y),
        .busy    (busy),
        .done    (done),
        .tt_out  (tt_out),
        .err_cnt (err_cnt),
        .pass    (pass)
    );

    logic_sweep_ctrl #(.N_IN(3), .SETTLE(0)) u_dut0 (
        .clk     (clk),
        .rst_n   (rst0_n),
        .start   (start0),
        .exp_tt  (exp_tt0),
        .dut_in  (dut_in0),
        .dut_y   (dut_y0),
        .busy    (busy0),
        .done    (done0),
        .tt_out  (tt_out0),
        .err_cnt (err_cnt0),
        .pass    (pass0)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        tests++;
        assert (obs === expv) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    // Advance one cycle; outputs are looked at 1 time unit after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference result for a full sweep of the a&b cell against a table.
    function automatic result_t model(input logic [7:0] expv);
        result_t r;
        for (int i = 0; i < 8; i++) begin
            logic [2:0] v;
            v = 3'(i);
            r.tt[i] = v[2] & v[1];
        end
        r.err  = 4'($countones(r.tt ^ expv));
        r.pass = (r.err == 4'd0);
        return r;
    endfunction

    task automatic pop_and_compare(input string tag, input logic [7:0] tt_o,
                                   input logic [3:0] err_o, input logic pass_o);
        result_t r;
        if (sb.size() == 0) begin
            check({tag, "_sb_empty"}, 32'd1, 32'd0);
        end else begin
            r = sb.pop_front();
            check({tag, "_tt"},   32'(tt_o),   32'(r.tt));
            check({tag, "_err"},  32'(err_o),  32'(r.err));
            check({tag, "_pass"}, 32'(pass_o), 32'(r.pass));
        end
    endtask

    // mode 0: plain sweep; mode 1: change exp_tt and re-pulse start at busy
    // cycle 10; mode 2: assert reset for one cycle at busy cycle 13.
    task automatic sweep_main(input string tag, input logic [7:0] expv, input int mode);
        int n;
        logic [7:0] tt_hold;
        sb.push_back(model(expv));
        exp_tt = expv;
        start  = 1'b1;
        tick();
        start  = 1'b0;
        n = 0;
        while (busy && n < 64) begin
            start = 1'b0;
            if (dut_in !== 3'(n / 3)) check({tag, "_dut_in_step"}, 32'(dut_in), 32'(n / 3));
            if (mode == 1 && n == 9) begin
                exp_tt = 8'h00;
                start  = 1'b1;
            end
            if (mode == 2 && n == 12) rst_n = 1'b0;
            n++;
            tick();
            if (mode == 2 && n == 13) break;
        end
        start = 1'b0;

        if (mode == 2) begin
            rst_n = 1'b1;
            check({tag, "_rst_busy"},   32'(busy),    32'd0);
            check({tag, "_rst_dut_in"}, 32'(dut_in),  32'd0);
            check({tag, "_rst_tt"},     32'(tt_out),  32'd0);
            check({tag, "_rst_err"},    32'(err_cnt), 32'd0);
            check({tag, "_rst_pass"},   32'(pass),    32'd0);
            check({tag, "_rst_done"},   32'(done),    32'd0);
            if (sb.size() != 0) void'(sb.pop_front());
            return;
        end

        check({tag, "_busy_cycles"}, 32'(n),      32'd24);
        check({tag, "_done"},        32'(done),   32'd1);
        check({tag, "_dut_in_wrap"}, 32'(dut_in), 32'd0);
        pop_and_compare(tag, tt_out, err_cnt, pass);
        tt_hold = tt_out;
        tick();
        check({tag, "_done_pulse"}, 32'(done),   32'd0);
        check({tag, "_busy_idle"},  32'(busy),   32'd0);
        check({tag, "_tt_hold"},    32'(tt_out), 32'(tt_hold));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "simulation did not finish");
    end

    initial begin
        rst_n   = 1'b0;
        start   = 1'b1;
        exp_tt  = 8'h00;
        rst0_n  = 1'b0;
        start0  = 1'b1;
        exp_tt0 = 8'hC0;

        // 1: reset held 3 cycles with start high -> everything stays 0.
        for (int i = 0; i < 3; i++) begin
            tick();
            check("reset_busy",   32'(busy),    32'd0);
            check("reset_done",   32'(done),    32'd0);
            check("reset_dut_in", 32'(dut_in),  32'd0);
            check("reset_tt",     32'(tt_out),  32'd0);
            check("reset_err",    32'(err_cnt), 32'd0);
            check("reset_pass",   32'(pass),    32'd0);
        end
        rst_n = 1'b1;
        start = 1'b0;
        tick();
        check("post_reset_idle", 32'(busy), 32'd0);

        // 2: matching table.
        sweep_main("t2", 8'hC0, 0);
        // 3: table for c|b -> four mismatches.
        sweep_main("t3", 8'hEE, 0);
        // 4: exp_tt change and start while busy are ignored.
        sweep_main("t4", 8'hC0, 1);
        // 5: reset mid-sweep, then a fresh full sweep.
        sweep_main("t5_abort", 8'hC0, 2);
        sweep_main("t5", 8'hC0, 0);

        // 6: SETTLE=0, start held high -> back-to-back 16-cycle sweeps.
        rst0_n = 1'b1;
        for (int s = 0; s < 2; s++) begin
            int n;
            sb.push_back(model(exp_tt0));
            n = 0;
            tick();
            check("t6_tt_cleared", 32'(tt_out0), 32'd0);
            while (busy0 && n < 64) begin
                if (dut_in0 !== 3'(n / 2)) check("t6_dut_in_step", 32'(dut_in0), 32'(n / 2));
                n++;
                tick();
            end
            check("t6_busy_cycles", 32'(n),     32'd16);
            check("t6_done",        32'(done0), 32'd1);
            pop_and_compare("t6", tt_out0, err_cnt0, pass0);
        end
        tick();
        check("t6_restart_busy", 32'(busy0), 32'd1);
        check("t6_done_pulse",   32'(done0), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
